// File: rtl/key_event_debounce_pkg.sv
// Shared types and helpers for the key event debouncer.
// Event word layout, integrator rail and log2 helper.
package key_event_debounce_pkg;

    // Event word: {key index, new level}
    localparam int STATE_BIT = 0;
    localparam int KEY_LSB   = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cmax(input int cnt_w);
        return (2 ** cnt_w) - 1;
    endfunction

    function automatic int evt_w(input int idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/key_event_debounce_if.sv
// Event stream bundle of the key debouncer.
// master drives valid/key/state/level, slave drives ready.
interface key_event_debounce_if #(
    parameter int IDX_W = 6,
    parameter int LVL_W = 4
) ();

    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [IDX_W-1:0] evt_key_o;
    logic             evt_state_o;
    logic [LVL_W-1:0] fifo_level_o;

    modport master (
        output evt_valid_o,
        output evt_key_o,
        output evt_state_o,
        output fifo_level_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_key_o,
        input  evt_state_o,
        input  fifo_level_o,
        output evt_ready_i
    );

endinterface

// File: rtl/key_event_debounce_sync_fifo.sv
// First-word-fall-through queue for key events.
// Ports: clk_i, rst_n_i, push_i/data_i, pop_i/data_o, level_o, full_o, empty_o.
module key_event_debounce_sync_fifo
    import key_event_debounce_pkg::*;
#(
    parameter int W     = 7,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [clog2(DEPTH):0]    level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] lvl_q;
    logic          push_ok;
    logic          pop_ok;

    // Full is judged on the level before this cycle's pop.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                lvl_q <= lvl_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                lvl_q <= lvl_q - 1'b1;
            end
        end
    end

    assign data_o  = mem_q[rd_q];
    assign level_o = lvl_q;
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);

endmodule

// File: rtl/key_event_debounce.sv
// Per-key synchroniser + integrator debouncer with a change-event queue.
// Ports: clk_i, rst_n_i, keys_i (raw), keys_o (debounced), evt (event stream master).
module key_event_debounce
    import key_event_debounce_pkg::*;
#(
    parameter int KEYS        = 61,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_STATE  = 1'b1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [KEYS-1:0] keys_i,
    output logic [KEYS-1:0] keys_o,
    key_event_debounce_if.master evt
);

    localparam int IDX_W = clog2(KEYS);
    localparam int EVT_W = evt_w(IDX_W);
    localparam int LVL_W = clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CMAX_V  = CNT_W'(cmax(CNT_W));
    localparam logic [CNT_W-1:0] CNT_RST = INIT_STATE ? CMAX_V : '0;
    localparam logic [IDX_W-1:0] PTR_END = IDX_W'(KEYS - 1);

    logic [KEYS-1:0]  synced;
    logic [CNT_W-1:0] cnt_q [KEYS];
    logic [KEYS-1:0]  state_q;
    logic [KEYS-1:0]  reported_q;
    logic [KEYS-1:0]  pending;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_nxt;
    logic             cur_pend;
    logic             cur_state;
    logic             push;
    logic             advance;
    logic [EVT_W-1:0] evt_word;
    logic [EVT_W-1:0] head;
    logic [LVL_W-1:0] level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    // Input synchroniser
    if (SYNC_STAGES == 0) begin : g_bypass
        assign synced = keys_i;
    end else begin : g_sync
        logic [KEYS-1:0] stg_q [SYNC_STAGES];

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    stg_q[i] <= {KEYS{INIT_STATE}};
                end
            end else begin
                stg_q[0] <= keys_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    stg_q[i] <= stg_q[i-1];
                end
            end
        end

        assign synced = stg_q[SYNC_STAGES-1];
    end

    // Saturating integrators and hysteretic level state
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < KEYS; k++) begin
                cnt_q[k] <= CNT_RST;
            end
            state_q <= {KEYS{INIT_STATE}};
        end else begin
            for (int k = 0; k < KEYS; k++) begin
                if (synced[k] && cnt_q[k] != CMAX_V) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end else if (!synced[k] && cnt_q[k] != '0) begin
                    cnt_q[k] <= cnt_q[k] - 1'b1;
                end
                if (state_q[k] && cnt_q[k] == '0) begin
                    state_q[k] <= 1'b0;
                end else if (!state_q[k] && cnt_q[k] == CMAX_V) begin
                    state_q[k] <= 1'b1;
                end
            end
        end
    end

    assign keys_o  = state_q;
    assign pending = state_q ^ reported_q;

    // Round-robin scanner: a pending key blocks the pointer while the
    // queue is full, so the change is reported later rather than lost.
    always_comb begin
        cur_pend  = pending[ptr_q];
        cur_state = state_q[ptr_q];
        push      = cur_pend && !fifo_full;
        advance   = !cur_pend || !fifo_full;
        ptr_nxt   = ptr_q;
        if (advance) begin
            ptr_nxt = (ptr_q == PTR_END) ? '0 : ptr_q + 1'b1;
        end
        evt_word                   = '0;
        evt_word[STATE_BIT]        = cur_state;
        evt_word[KEY_LSB +: IDX_W] = ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            reported_q <= {KEYS{INIT_STATE}};
            ptr_q      <= '0;
        end else begin
            ptr_q <= ptr_nxt;
            if (push) begin
                reported_q[ptr_q] <= cur_state;
            end
        end
    end

    assign pop = evt.evt_valid_o && evt.evt_ready_i;

    key_event_debounce_sync_fifo #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (evt_word),
        .pop_i   (pop),
        .data_o  (head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt.evt_valid_o  = !fifo_empty;
    assign evt.evt_key_o    = head[KEY_LSB +: IDX_W];
    assign evt.evt_state_o  = head[STATE_BIT];
    assign evt.fifo_level_o = level;

endmodule

// File: tb/tb_key_event_debounce.sv
// Testbench for key_event_debounce: directed scenarios plus random stimulus
// compared every cycle against a behavioural model.
module tb_key_event_debounce;

    localparam int KEYS  = 4;
    localparam int DEPTH = 2;
    localparam int CMAXM = 7;

    logic       clk;
    logic       rst_n;
    logic [3:0] keys;
    logic [3:0] keys_o;

    int checks = 0;
    int errors = 0;

    key_event_debounce_if #(.IDX_W(2), .LVL_W(2)) evt_if ();

    key_event_debounce #(
        .KEYS        (KEYS),
        .CNT_W       (3),
        .SYNC_STAGES (2),
        .INIT_STATE  (1'b1),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .keys_i  (keys),
        .keys_o  (keys_o),
        .evt     (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: inputs seen two cycles late, saturating
    // integrators, hysteresis, and a queue of (key*2+level) events.
    bit [3:0] ms0, ms1, mst, mrep;
    int       mcnt [4];
    int       mptr;
    int       mq [$];
    bit       live = 1'b0;
    bit       do_pop;
    bit       mfull;

    always @(posedge clk) begin
        if (!rst_n) begin
            ms0 = 4'hF;
            ms1 = 4'hF;
            mst = 4'hF;
            mrep = 4'hF;
            for (int k = 0; k < 4; k++) mcnt[k] = CMAXM;
            mptr = 0;
            mq.delete();
            live = 1'b1;
        end else if (live) begin
            do_pop = (mq.size() != 0) && evt_if.evt_ready_i;
            mfull  = (mq.size() == DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (mst[mptr] != mrep[mptr]) begin
                if (!mfull) begin
                    mq.push_back(mptr * 2 + int'(mst[mptr]));
                    mrep[mptr] = mst[mptr];
                    mptr = (mptr + 1) % KEYS;
                end
            end else begin
                mptr = (mptr + 1) % KEYS;
            end
            for (int k = 0; k < 4; k++) begin
                if (mst[k] && mcnt[k] == 0) mst[k] = 1'b0;
                else if (!mst[k] && mcnt[k] == CMAXM) mst[k] = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (ms1[k]) mcnt[k] = (mcnt[k] < CMAXM) ? mcnt[k] + 1 : mcnt[k];
                else mcnt[k] = (mcnt[k] > 0) ? mcnt[k] - 1 : 0;
            end
            ms1 = ms0;
            ms0 = keys;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_keys", 32'(keys_o), 32'(mst));
            chk("m_valid", 32'(evt_if.evt_valid_o), 32'(mq.size() != 0));
            chk("m_level", 32'(evt_if.fifo_level_o), 32'(mq.size()));
            if (mq.size() != 0)
                chk("m_head", 32'({evt_if.evt_key_o, evt_if.evt_state_o}),
                    32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level2(input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (evt_if.fifo_level_o == 2'd2) hit = 1'b1;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    bit       seen;
    bit       got;
    int       n_ev;
    int       n_k3;
    bit [3:0] kmask;
    bit       bad_st;

    initial begin
        rst_n = 1'b0;
        keys = 4'hF;
        evt_if.evt_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_keys", 32'(keys_o), 32'hF);
        chk("rst_valid", 32'(evt_if.evt_valid_o), 32'd0);
        chk("rst_level", 32'(evt_if.fifo_level_o), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (evt_if.evt_valid_o) seen = 1'b1;
        end
        chk("idle_no_evt", 32'(seen), 32'd0);

        // Key 2 release: 2 sync + 8 integrate cycles
        tick();
        keys[2] = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("k2_hold", 32'(keys_o[2]), 32'd1);
        tick();
        chk("k2_flip", 32'(keys_o[2]), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid_o && !got) begin
                got = 1'b1;
                chk("k2_evt_key", 32'(evt_if.evt_key_o), 32'd2);
                chk("k2_evt_st", 32'(evt_if.evt_state_o), 32'd0);
            end
        end
        chk("k2_evt_seen", 32'(got), 32'd1);

        // 5-cycle glitch on key 1
        tick();
        keys[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1 keys[1] = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (keys_o[1] != 1'b1 || evt_if.evt_valid_o) seen = 1'b1;
        end
        chk("glitch_quiet", 32'(seen), 32'd0);

        // Back-pressure: three keys drop with ready low
        tick();
        evt_if.evt_ready_i = 1'b0;
        keys = 4'b0000;
        wait_level2("bp_fill");
        repeat (10) @(negedge clk);
        chk("bp_stall_lvl", 32'(evt_if.fifo_level_o), 32'd2);
        chk("bp_keys", 32'(keys_o), 32'd0);
        tick();
        evt_if.evt_ready_i = 1'b1;
        n_ev = 0;
        kmask = '0;
        bad_st = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (evt_if.evt_valid_o) begin
                n_ev++;
                kmask[evt_if.evt_key_o] = 1'b1;
                if (evt_if.evt_state_o != 1'b0) bad_st = 1'b1;
            end
        end
        chk("bp_count", 32'(n_ev), 32'd3);
        chk("bp_keyset", 32'(kmask), 32'b1011);
        chk("bp_state", 32'(bad_st), 32'd0);

        // Net-zero flip of key 3 while the queue is full
        tick();
        evt_if.evt_ready_i = 1'b0;
        keys = 4'b0011;
        wait_level2("nz_fill");
        tick();
        keys[3] = 1'b1;
        repeat (20) @(negedge clk);
        chk("nz_k3_up", 32'(keys_o[3]), 32'd1);
        chk("nz_full", 32'(evt_if.fifo_level_o), 32'd2);
        tick();
        keys[3] = 1'b0;
        repeat (20) @(negedge clk);
        chk("nz_k3_dn", 32'(keys_o[3]), 32'd0);
        tick();
        evt_if.evt_ready_i = 1'b1;
        n_ev = 0;
        n_k3 = 0;
        repeat (12) begin
            @(negedge clk);
            if (evt_if.evt_valid_o) begin
                n_ev++;
                if (evt_if.evt_key_o == 2'd3) n_k3++;
            end
        end
        chk("nz_count", 32'(n_ev), 32'd2);
        chk("nz_k3_evts", 32'(n_k3), 32'd0);

        // Reset with two events queued
        tick();
        evt_if.evt_ready_i = 1'b0;
        keys = 4'b0000;
        wait_level2("rq_fill");
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rq_valid", 32'(evt_if.evt_valid_o), 32'd0);
        chk("rq_keys", 32'(keys_o), 32'hF);
        chk("rq_level", 32'(evt_if.fifo_level_o), 32'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rq_cnt%0d", k), 32'(dut.cnt_q[k]), 32'd7);

        // Random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            evt_if.evt_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                int k;
                k = $urandom_range(0, 3);
                keys[k] = ~keys[k];
            end
            rst_n = ($urandom_range(0, 999) != 0);
        end
        tick();
        rst_n = 1'b1;
        evt_if.evt_ready_i = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_debounce.md
# key_event_debounce

Parametrised per-key debouncer for the keyboard matrix inputs. It adds input synchronisation, a configurable integrator width and reset level, and a round-robin change scanner that turns debounced level changes into a queued event stream (key index plus new level) with a valid/ready handshake. It sits between the raw key inputs and the report/host logic. It supplies both the live debounced state vector and a lossless change-event queue.

## Interface
- KEYS, 61, number of key inputs (≥2)
- CNT_W, 3, integrator counter width; CMAX = 2^CNT_W−1
- SYNC_STAGES, 2, input synchroniser flops per key (0 = bypass)
- INIT_STATE, 1, debounced level of every key after reset
- FIFO_DEPTH, 8, event queue depth, power of two ≥2
- IDX_W, $clog2(KEYS), key index width (derived)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- keys_i  in  KEYS  raw key levels, asynchronous
- keys_o  out  KEYS  debounced levels
- evt_valid_o  out  1  queue non-empty
- evt_ready_i  in  1  consumer accepts head event
- evt_key_o  out  IDX_W  key index of head event
- evt_state_o  out  1  new debounced level of head event
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  queued event count

## Operation
- Synchroniser: SYNC_STAGES flops per key. The reset value is INIT_STATE replicated.
- Integrator, per key:
  - If the synced input is 1 and cnt≠CMAX: cnt+1.
  - Else if the synced input is 0 and cnt≠0: cnt−1.
  - Otherwise hold. Saturating, no wrap.
  - Reset value: CMAX if INIT_STATE=1, else 0.
- Level state, per key:
  - state 1→0 when cnt==0.
  - state 0→1 when cnt==CMAX.
  - Otherwise hold (hysteresis).
  - Reset value: INIT_STATE. keys_o = state.
- Shadow register reported[KEYS], reset INIT_STATE. pending[k] = state[k] XOR reported[k].
- Scanner pointer ptr, reset 0:
  - Each cycle, if pending[ptr] and the FIFO is not full: push {ptr, state[ptr]}, set reported[ptr] <= state[ptr], advance ptr.
  - If pending[ptr] and the FIFO is full: ptr holds; nothing is lost.
  - If not pending: advance.
  - ptr wraps from KEYS−1 to 0.
- Collapsing: several flips of one key between visits yield a single event carrying the current level. A net-zero change yields no event.
- FIFO is first-word-fall-through:
  - evt_valid_o = level≠0. Pop when evt_valid_o && evt_ready_i.
  - Push is gated on full evaluated before this cycle's pop; there is no full-bypass.
  - Simultaneous push and pop when not full: level unchanged.
- evt_key_o and evt_state_o are don't-care while evt_valid_o=0. The bench checks them only when valid.
- Reset mid-operation:
  - Counters, synchroniser, state, reported, ptr and FIFO all return to reset values on the same edge.
  - Queued events are discarded.
  - No event is generated for the reset transition itself.

## Timing
- keys_i change to synced change: SYNC_STAGES cycles.
- Synced input steady after a full-scale counter: keys_o flips CMAX+1 cycles later. For CNT_W=3 that is 8 cycles.
- A glitch shorter than the counter distance to its rail never flips keys_o.
- keys_o flip to push: 0..KEYS−1 cycles, depending on ptr. It is longer only while the FIFO is full.
- Push to evt_valid_o high: 1 cycle.
- Pop to the next head on outputs: 1 cycle. Sustained throughput is 1 event/cycle.
- All outputs are registered or decode directly from registers. There is no combinational path from evt_ready_i to any output except via the FIFO state update.

## Structure
- keys_pkg holds:
  - the event word layout (KEY_LSB, STATE_BIT, EVT_W = IDX_W+1);
  - the CMAX function of CNT_W;
  - the clog2 helper.
- Sub-module sync_fifo (width EVT_W, depth FIFO_DEPTH): storage, pointers, level, full/empty.
- The synchroniser, integrators, state, reported and scanner stay in the top.

## Test plan
Bench parameters: KEYS=4, CNT_W=3, SYNC_STAGES=2, FIFO_DEPTH=2.
- Reset with keys_i=4'b1111:
  - keys_o=4'b1111, evt_valid_o=0, fifo_level_o=0.
  - No event appears over 20 cycles.
- Drop keys_i[2] to 0 and hold:
  - keys_o[2]=0 exactly 2+8 cycles later.
  - One event, key=2, state=0, valid within 4 cycles after that.
- Pulse keys_i[1] low for 5 cycles, then high: keys_o[1] never changes and no event is produced.
- With evt_ready_i=0, drop keys 0, 1 and 3 together:
  - Events key=0 and key=1 are queued; level reaches 2.
  - ptr stalls on key 3.
  - Raise ready: events for keys 0, 1 and 3 emerge in that order, each state=0, with no loss.
- On one key, flip the level 0→1 and back 1→0, each debounced, while the FIFO is full: after drain, that key produces at most one event, carrying state 0 (or none if net-zero versus reported).
- Assert rst_n_i low for 1 cycle with 2 events queued: the next cycle has evt_valid_o=0, keys_o=4'b1111, and counters at 7.
